// File: rtl/sap_datapath.sv
// SAP-1 style datapath: shared 8-bit bus, PC/MAR/IR/ACC/B/OUT/AR registers and a 4-function ALU.
// The control sequencer drives the strobes; this block only moves and transforms data.
module sap_datapath (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       PC_LD,
  input  logic       PC_OE,
  input  logic       MAR_LD,
  input  logic       ROM_OE,
  input  logic       IR_LD,
  input  logic       IR_OE,
  input  logic       ACC_LD,
  input  logic       ACC_OE,
  input  logic       S0,
  input  logic       S1,
  input  logic       ALU_en,
  input  logic       B_LD,
  input  logic       OUT_LD,
  input  logic       AR_LD,
  input  logic       AR_OE,
  input  logic       HLT,
  input  logic [7:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] op_code,
  output logic [7:0] out_port,
  output logic       carry,
  output logic       zero,
  output logic       halted,
  output logic       bus_err
);

  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [7:0] b;
  logic [7:0] out_reg;
  logic [7:0] ar;
  logic [7:0] bus;
  logic [8:0] alu_sum;
  logic [7:0] alu_y;
  logic       alu_c;
  logic [2:0] drv_cnt;
  logic       conflict;
  logic       upd;

  always_comb begin
    case ({S1, S0})
      2'b00:   alu_sum = {1'b0, acc} + {1'b0, b};
      2'b01:   alu_sum = {1'b0, acc} + {1'b0, ~b} + 9'd1;
      2'b10:   alu_sum = {1'b0, acc & b};
      default: alu_sum = {1'b0, acc | b};
    endcase
  end

  assign alu_y = alu_sum[7:0];
  assign alu_c = alu_sum[8];

  // Fixed priority keeps the bus defined even when the sequencer misbehaves.
  always_comb begin
    bus = 8'h00;
    if (PC_OE)        bus = {4'h0, pc};
    else if (!ROM_OE) bus = rom_data;
    else if (!IR_OE)  bus = {4'h0, ir[3:0]};
    else if (!ALU_en) bus = alu_y;
    else if (!ACC_OE) bus = acc;
    else if (!AR_OE)  bus = ar;
  end

  assign drv_cnt = 3'(PC_OE) + 3'(!ROM_OE) + 3'(!IR_OE) + 3'(!ALU_en)
                 + 3'(!ACC_OE) + 3'(!AR_OE);
  assign conflict = drv_cnt > 3'd1;

  // The halting edge itself is also frozen, so HLT gates updates directly.
  assign upd = !halted && HLT;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      acc     <= 8'h00;
      b       <= 8'h00;
      out_reg <= 8'h00;
      ar      <= 8'h00;
      carry   <= 1'b0;
      zero    <= 1'b0;
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (conflict) bus_err <= 1'b1;
      if (!HLT)     halted  <= 1'b1;
      if (upd) begin
        if (PC_LD)    pc <= bus[3:0];
        else if (inc) pc <= pc + 4'd1;
        if (MAR_LD) mar     <= bus[3:0];
        if (IR_LD)  ir      <= bus;
        if (ACC_LD) acc     <= bus;
        if (B_LD)   b       <= bus;
        if (OUT_LD) out_reg <= bus;
        if (AR_LD)  ar      <= bus;
        if (ACC_LD && !ALU_en) begin
          carry <= alu_c;
          zero  <= (alu_y == 8'h00);
        end
      end
    end
  end

  assign rom_addr = mar;
  assign op_code  = ir[7:4];
  assign out_port = out_reg;

endmodule

// File: doc/sap_datapath.md
SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and clr.
REQ-002 The port list SHALL be, in this order:
- clk  in  1  system clock
- clr  in  1  async active-high reset
- inc  in  1  PC increment strobe
- PC_LD  in  1  PC load from bus[3:0]
- PC_OE  in  1  PC drives bus, active-high
- MAR_LD  in  1  MAR load from bus[3:0]
- ROM_OE  in  1  rom_data drives bus, active-low
- IR_LD  in  1  IR load from bus
- IR_OE  in  1  IR[3:0] drives bus, active-low
- ACC_LD  in  1  ACC load from bus
- ACC_OE  in  1  ACC drives bus, active-low
- S0, S1  in  1 each  ALU operation select
- ALU_en  in  1  ALU result drives bus, active-low
- B_LD  in  1  B load from bus
- OUT_LD  in  1  OUT load from bus
- AR_LD  in  1  AR load from bus
- AR_OE  in  1  AR drives bus, active-low
- HLT  in  1  halt request, active-low
- rom_data  in  8  ROM read data
- rom_addr  out  4  ROM address (= MAR)
- op_code  out  4  IR[7:4], to control sequencer
- out_port  out  8  OUT register
- carry  out  1  ALU carry/borrow flag
- zero  out  1  ALU zero flag
- halted  out  1  sticky halt status
- bus_err  out  1  sticky multiple-driver flag

Function
REQ-003 Internal 8-bit bus SHALL be combinational; drivers: PC_OE -> {4'h0,PC}; !ROM_OE -> rom_data; !IR_OE -> {4'h0,IR[3:0]}; !ACC_OE -> ACC; !ALU_en -> alu_y; !AR_OE -> AR.
REQ-004 With no driver asserted, bus SHALL be 8'h00.
REQ-005 With more than one driver asserted, bus SHALL take the highest-priority one (PC > ROM > IR > ALU > ACC > AR), and bus_err SHALL be set on that clock edge and held until clr.
REQ-006 ALU SHALL compute from ACC (A) and B: {S1,S0}=00 A+B; 01 A-B (A + ~B + 1); 10 A&B; 11 A|B; alu_y is the low 8 bits.
REQ-007 ALU carry output SHALL be bit 8 of the 9-bit sum for 00/01 (01: 1 = no borrow) and 0 for 10/11.
REQ-008 On an edge with ACC_LD=1 and ALU_en=0, carry SHALL load the ALU carry output and zero SHALL load (alu_y==0); on any other edge both flags SHALL hold.
REQ-009 All register loads SHALL occur on the rising clk edge, using the bus value present before that edge.
REQ-010 PC SHALL be 4 bits: PC_LD loads bus[3:0]; otherwise inc increments it modulo 16 (15 -> 0); when both are asserted, PC_LD SHALL win.
REQ-011 MAR, IR, ACC, B, OUT and AR SHALL each load on their _LD strobe and hold otherwise.
REQ-012 A register both driving and loading the bus in one cycle SHALL reload its own value.
REQ-013 rom_addr SHALL equal MAR, op_code SHALL equal IR[7:4], and out_port SHALL equal OUT, all combinational from the registers.
REQ-014 A rising edge sampling HLT=0 SHALL set halted, which SHALL hold until clr.
REQ-015 While halted=1, every register and flag update SHALL be suppressed, including the edge that sets halted; bus_err still updates.

Reset
REQ-016 clr=1 SHALL immediately and asynchronously clear PC, MAR, IR, ACC, B, OUT, AR, carry, zero, halted and bus_err to 0, independent of clk.
REQ-017 Reset mid-instruction SHALL discard all state; the first edge after clr deasserts SHALL behave as a normal edge.

Verification
REQ-018 Fetch: PC=3, rom_data=8'h1A; assert PC_OE+MAR_LD, then ROM_OE=0+IR_LD+inc -> rom_addr=3, op_code=1, PC=4.
REQ-019 Add with flags: ACC=8'hF0, B=8'h20, S=00, ALU_en=0+ACC_LD -> ACC=8'h10, carry=1, zero=0. Then ACC=B=8'h55, S=01 -> ACC=8'h00, carry=1, zero=1.
REQ-020 Wrap and priority: PC=15 with inc -> PC=0. Then PC_LD with bus=8'h07 plus inc -> PC=7.
REQ-021 Bus conflict: PC_OE=1 and ACC_OE=0 together -> bus = PC value and bus_err=1. bus_err stays 1 after the drivers release, until clr.
REQ-022 Halt: OUT_LD with ACC=8'h2C (ACC_OE=0) -> out_port=8'h2C. Then HLT=0 -> halted=1, and later ACC_LD/inc strobes leave ACC and PC unchanged.
REQ-023 Async reset: assert clr between edges with all registers nonzero -> every output reads 0 before the next clk edge.
